// File: rtl/mistral_mul_seq.sv
// Iterative tiled multiplier: one signed (TILE+1)x(TILE+1) partial product per cycle into a wide accumulator.
// Optional build macro MISTRAL_MUL_SEQ_PIPE_EN adds a register between the tile multiplier and the accumulator.
module mistral_mul_seq #(
    parameter int A_WIDTH  = 54,
    parameter int B_WIDTH  = 54,
    parameter int A_SIGNED = 1,
    parameter int B_SIGNED = 1,
    parameter int TILE     = 26,
    parameter int Y_WIDTH  = 108
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [A_WIDTH-1:0] A,
    input  logic [B_WIDTH-1:0] B,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [Y_WIDTH-1:0] Y
);

    localparam int NA   = (A_WIDTH + TILE - 1) / TILE;
    localparam int NB   = (B_WIDTH + TILE - 1) / TILE;
    localparam int AW   = NA * TILE;
    localparam int BW   = NB * TILE;
    localparam int ACCW = (NA + NB) * TILE;
    localparam int PPW  = 2 * TILE + 2;
    localparam int WIDE = ACCW + PPW;
    localparam logic [7:0] NA_LAST = 8'(NA - 1);
    localparam logic [7:0] NB_LAST = 8'(NB - 1);

    typedef enum logic [1:0] {IDLE, MUL, LOAD, DONE} state_t;

    state_t              state_q;
    logic [AW-1:0]       a_q;
    logic [BW-1:0]       b_q;
    logic [7:0]          i_q;
    logic [7:0]          j_q;
    logic [ACCW-1:0]     acc_q;
    logic [ACCW-1:0]     acc_d;
    logic [Y_WIDTH-1:0]  y_q;
    logic                inReady_q;
    logic                outValid_q;

    logic [AW-1:0]       aExt;
    logic [BW-1:0]       bExt;
    logic signed [A_WIDTH:0] aSx;
    logic signed [B_WIDTH:0] bSx;
    logic [TILE-1:0]     aTileRaw;
    logic [TILE-1:0]     bTileRaw;
    logic signed [TILE:0] aTile;
    logic signed [TILE:0] bTile;
    logic signed [PPW-1:0] pp;
    logic [ACCW-1:0]     ppAligned;
    logic signed [ACCW:0] accSx;
    logic [Y_WIDTH-1:0]  yExt;
    logic                lastTile;
    int                  aIdx;
    int                  bIdx;
    int                  shamt;

`ifdef MISTRAL_MUL_SEQ_PIPE_EN
    logic [ACCW-1:0]     pipe_q;
    logic                pipeValid_q;
    logic                issued_q;
`endif

    // Operand extension, tile selection and the single tile multiplier
    always_comb begin
        aSx      = {(A_SIGNED != 0) ? A[A_WIDTH-1] : 1'b0, A};
        bSx      = {(B_SIGNED != 0) ? B[B_WIDTH-1] : 1'b0, B};
        aExt     = AW'(aSx);
        bExt     = BW'(bSx);
        aIdx     = int'(i_q) * TILE;
        bIdx     = int'(j_q) * TILE;
        aTileRaw = a_q[aIdx +: TILE];
        bTileRaw = b_q[bIdx +: TILE];
        // Only the top tile of a signed operand carries the sign; lower tiles are magnitudes
        aTile    = {(A_SIGNED != 0 && i_q == NA_LAST) ? aTileRaw[TILE-1] : 1'b0, aTileRaw};
        bTile    = {(B_SIGNED != 0 && j_q == NB_LAST) ? bTileRaw[TILE-1] : 1'b0, bTileRaw};
        pp       = PPW'(aTile) * PPW'(bTile);
        shamt    = (int'(i_q) + int'(j_q)) * TILE;
        ppAligned = ACCW'(WIDE'(pp) << shamt);
        lastTile = (i_q == NA_LAST) && (j_q == NB_LAST);
`ifdef MISTRAL_MUL_SEQ_PIPE_EN
        acc_d    = acc_q + pipe_q;
`else
        acc_d    = acc_q + ppAligned;
`endif
        accSx    = {(A_SIGNED != 0 || B_SIGNED != 0) ? acc_q[ACCW-1] : 1'b0, acc_q};
        yExt     = Y_WIDTH'(accSx);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            i_q         <= '0;
            j_q         <= '0;
            acc_q       <= '0;
            y_q         <= '0;
            inReady_q   <= 1'b1;
            outValid_q  <= 1'b0;
`ifdef MISTRAL_MUL_SEQ_PIPE_EN
            pipe_q      <= '0;
            pipeValid_q <= 1'b0;
            issued_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (IN_VALID) begin
                        a_q       <= aExt;
                        b_q       <= bExt;
                        acc_q     <= '0;
                        i_q       <= '0;
                        j_q       <= '0;
                        inReady_q <= 1'b0;
                        state_q   <= MUL;
`ifdef MISTRAL_MUL_SEQ_PIPE_EN
                        pipe_q      <= '0;
                        pipeValid_q <= 1'b0;
                        issued_q    <= 1'b0;
`endif
                    end
                end
                MUL: begin
`ifdef MISTRAL_MUL_SEQ_PIPE_EN
                    // Issue tiles until all are in flight, then spend one cycle draining the pipe
                    if (pipeValid_q) begin
                        acc_q <= acc_d;
                    end
                    if (!issued_q) begin
                        pipe_q      <= ppAligned;
                        pipeValid_q <= 1'b1;
                        issued_q    <= lastTile;
                        if (j_q == NB_LAST) begin
                            j_q <= '0;
                            i_q <= i_q + 8'd1;
                        end else begin
                            j_q <= j_q + 8'd1;
                        end
                    end else begin
                        pipeValid_q <= 1'b0;
                        state_q     <= LOAD;
                    end
`else
                    acc_q <= acc_d;
                    if (j_q == NB_LAST) begin
                        j_q <= '0;
                        i_q <= i_q + 8'd1;
                    end else begin
                        j_q <= j_q + 8'd1;
                    end
                    if (lastTile) begin
                        state_q <= LOAD;
                    end
`endif
                end
                LOAD: begin
                    y_q        <= yExt;
                    outValid_q <= 1'b1;
                    state_q    <= DONE;
                end
                DONE: begin
                    if (OUT_READY) begin
                        outValid_q <= 1'b0;
                        inReady_q  <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign IN_READY  = inReady_q;
    assign OUT_VALID = outValid_q;
    assign Y         = y_q;

endmodule

// File: tb/tb_mistral_mul_seq.sv
// Scoreboard bench for mistral_mul_seq: default signed 54x54, unsigned 54x54 and signed 18x18 instances.
module tb_mistral_mul_seq;

`ifdef MISTRAL_MUL_SEQ_PIPE_EN
    localparam int PIPE_EXTRA = 1;
`else
    localparam int PIPE_EXTRA = 0;
`endif
    localparam int LAT54 = 9 + 1 + PIPE_EXTRA;
    localparam int LAT18 = 1 + 1 + PIPE_EXTRA;

    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    logic         v0, r0, ov0, or0;
    logic [53:0]  a0, b0;
    logic [107:0] y0;
    logic         v1, r1, ov1, or1;
    logic [53:0]  a1, b1;
    logic [107:0] y1;
    logic         v2, r2, ov2, or2;
    logic [17:0]  a2, b2;
    logic [107:0] y2;

    int checks = 0;
    int fails  = 0;
    logic [107:0] sbq[$];

    mistral_mul_seq dut0 (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(v0), .IN_READY(r0), .A(a0), .B(b0),
        .OUT_VALID(ov0), .OUT_READY(or0), .Y(y0)
    );

    mistral_mul_seq #(.A_SIGNED(0), .B_SIGNED(0)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(v1), .IN_READY(r1), .A(a1), .B(b1),
        .OUT_VALID(ov1), .OUT_READY(or1), .Y(y1)
    );

    mistral_mul_seq #(.A_WIDTH(18), .B_WIDTH(18)) dut2 (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(v2), .IN_READY(r2), .A(a2), .B(b2),
        .OUT_VALID(ov2), .OUT_READY(or2), .Y(y2)
    );

    // Reference product of the default signed instance, taken straight from the operands
    function automatic logic [107:0] model0(input logic [53:0] a, input logic [53:0] b);
        logic signed [107:0] sa;
        logic signed [107:0] sb;
        sa = 108'($signed(a));
        sb = 108'($signed(b));
        return sa * sb;
    endfunction

    task automatic start0(input logic [53:0] a, input logic [53:0] b);
        int n;
        n = 0;
        @(negedge CLK);
        a0 = a;
        b0 = b;
        v0 = 1'b1;
        while (!r0 && n < 300) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 300) begin
            checks++;
            fails++;
            $display("[TB] FAIL accept_timeout: IN_READY got %b required 1", r0);
        end
        @(posedge CLK);
        sbq.push_back(model0(a, b));
        @(negedge CLK);
        v0 = 1'b0;
        a0 = 54'($urandom());
        b0 = 54'($urandom());
    endtask

    // Counts edges after the accept edge until OUT_VALID is seen, bounded
    task automatic waitOut0(output logic [107:0] y, output int lat);
        lat = 0;
        while (!ov0 && lat < 300) begin
            @(negedge CLK);
            lat++;
        end
        y = y0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        v0 = 0; v1 = 0; v2 = 0;
        or0 = 1; or1 = 1; or2 = 1;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        checks++; if (r0 !== 1'b1)    begin fails++; $display("[TB] FAIL reset_in_ready: got %b required 1", r0); end
        checks++; if (ov0 !== 1'b0)   begin fails++; $display("[TB] FAIL reset_out_valid: got %b required 0", ov0); end
        checks++; if (y0 !== 108'd0)  begin fails++; $display("[TB] FAIL reset_y: got %h required 0", y0); end
        checks++; if (r1 !== 1'b1)    begin fails++; $display("[TB] FAIL reset_in_ready_u: got %b required 1", r1); end
        checks++; if (ov2 !== 1'b0)   begin fails++; $display("[TB] FAIL reset_out_valid_18: got %b required 0", ov2); end
    endtask

    task automatic test_basic();
        logic [107:0] y, e;
        int lat;
        or0 = 1'b1;
        start0(54'd3, 54'd5);
        waitOut0(y, lat);
        e = sbq.pop_front();
        checks++; if (y !== e)          begin fails++; $display("[TB] FAIL basic_y: got %h required %h", y, e); end
        checks++; if (y !== 108'd15)    begin fails++; $display("[TB] FAIL basic_y_const: got %h required f", y); end
        checks++; if (lat !== LAT54)    begin fails++; $display("[TB] FAIL basic_latency: got %0d required %0d", lat, LAT54); end
        @(negedge CLK);
        checks++; if (ov0 !== 1'b0 || r0 !== 1'b1) begin
            fails++; $display("[TB] FAIL basic_handshake: OUT_VALID %b IN_READY %b required 0 1", ov0, r0);
        end
    endtask

    task automatic test_neg_ones();
        logic [107:0] y, e, c;
        logic [53:0] a, b;
        int lat;
        a = {54{1'b1}};
        b = {1'b0, {53{1'b1}}};
        c = ~((108'd1 << 53) - 108'd1) + 108'd1;
        start0(a, b);
        waitOut0(y, lat);
        e = sbq.pop_front();
        checks++; if (y !== c)       begin fails++; $display("[TB] FAIL neg_ones_y: got %h required %h", y, c); end
        checks++; if (y !== e)       begin fails++; $display("[TB] FAIL neg_ones_model: got %h required %h", y, e); end
        checks++; if (lat !== LAT54) begin fails++; $display("[TB] FAIL neg_ones_latency: got %0d required %0d", lat, LAT54); end
        @(negedge CLK);
    endtask

    task automatic test_unsigned();
        logic [107:0] c;
        int lat;
        c = 108'd1 - (108'd1 << 55);
        @(negedge CLK);
        a1 = {54{1'b1}};
        b1 = {54{1'b1}};
        v1 = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        v1 = 1'b0;
        a1 = '0;
        b1 = '0;
        lat = 0;
        while (!ov1 && lat < 300) begin
            @(negedge CLK);
            lat++;
        end
        checks++; if (y1 !== c)      begin fails++; $display("[TB] FAIL unsigned_y: got %h required %h", y1, c); end
        checks++; if (lat !== LAT54) begin fails++; $display("[TB] FAIL unsigned_latency: got %0d required %0d", lat, LAT54); end
        @(negedge CLK);
    endtask

    task automatic test_stall();
        logic [107:0] y, e;
        int lat;
        or0 = 1'b0;
        start0(54'h2A_5A5A_1234_5678, 54'h3F_0F0F_8765_4321);
        waitOut0(y, lat);
        e = sbq.pop_front();
        checks++; if (y !== e) begin fails++; $display("[TB] FAIL stall_y: got %h required %h", y, e); end
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            checks++; if (ov0 !== 1'b1) begin fails++; $display("[TB] FAIL stall_valid[%0d]: got %b required 1", k, ov0); end
            checks++; if (y0 !== e)     begin fails++; $display("[TB] FAIL stall_hold[%0d]: got %h required %h", k, y0, e); end
            checks++; if (r0 !== 1'b0)  begin fails++; $display("[TB] FAIL stall_in_ready[%0d]: got %b required 0", k, r0); end
        end
        or0 = 1'b1;
        @(negedge CLK);
        checks++; if (ov0 !== 1'b0 || r0 !== 1'b1) begin
            fails++; $display("[TB] FAIL stall_release: OUT_VALID %b IN_READY %b required 0 1", ov0, r0);
        end
    endtask

    task automatic test_reset_mid();
        logic [107:0] y, e, c;
        int lat;
        or0 = 1'b1;
        start0(54'd11, 54'd13);
        repeat (3) @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        sbq.delete();
        checks++; if (ov0 !== 1'b0)  begin fails++; $display("[TB] FAIL midreset_valid: got %b required 0", ov0); end
        checks++; if (y0 !== 108'd0) begin fails++; $display("[TB] FAIL midreset_y: got %h required 0", y0); end
        checks++; if (r0 !== 1'b1)   begin fails++; $display("[TB] FAIL midreset_in_ready: got %b required 1", r0); end
        c = 108'd0 - 108'd21;
        start0(54'd7, 54'd0 - 54'd3);
        waitOut0(y, lat);
        e = sbq.pop_front();
        checks++; if (y !== c)       begin fails++; $display("[TB] FAIL midreset_y_new: got %h required %h", y, c); end
        checks++; if (y !== e)       begin fails++; $display("[TB] FAIL midreset_model: got %h required %h", y, e); end
        checks++; if (lat !== LAT54) begin fails++; $display("[TB] FAIL midreset_latency: got %0d required %0d", lat, LAT54); end
        @(negedge CLK);
    endtask

    task automatic test_tile18();
        logic [107:0] c;
        int lat;
        c = 108'd1 << 34;
        @(negedge CLK);
        a2 = 18'h20000;
        b2 = 18'h20000;
        v2 = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        v2 = 1'b0;
        a2 = 18'h00001;
        lat = 0;
        while (!ov2 && lat < 300) begin
            @(negedge CLK);
            lat++;
        end
        checks++; if (y2 !== c)      begin fails++; $display("[TB] FAIL tile18_y: got %h required %h", y2, c); end
        checks++; if (lat !== LAT18) begin fails++; $display("[TB] FAIL tile18_latency: got %0d required %0d", lat, LAT18); end
        @(negedge CLK);
    endtask

    task automatic test_back_to_back();
        logic [107:0] y, e;
        logic [63:0] ra, rb;
        int lat, stall;
        for (int n = 0; n < 10; n++) begin
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            if (n == 0) begin ra = 64'h20_0000_0000_0000; rb = 64'h20_0000_0000_0000; end
            if (n == 1) begin ra = 64'h1F_FFFF_FFFF_FFFF; rb = 64'h20_0000_0000_0000; end
            if (n == 2) begin ra = 64'h0; end
            stall = $urandom_range(0, 3);
            or0 = (stall == 0);
            start0(ra[53:0], rb[53:0]);
            waitOut0(y, lat);
            e = sbq.pop_front();
            checks++; if (y !== e)       begin fails++; $display("[TB] FAIL b2b_y[%0d]: got %h required %h", n, y, e); end
            checks++; if (lat !== LAT54) begin fails++; $display("[TB] FAIL b2b_latency[%0d]: got %0d required %0d", n, lat, LAT54); end
            repeat (stall) @(negedge CLK);
            or0 = 1'b1;
            @(negedge CLK);
            checks++; if (ov0 !== 1'b0) begin fails++; $display("[TB] FAIL b2b_release[%0d]: got %b required 0", n, ov0); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_neg_ones();
        test_unsigned();
        test_stall();
        test_reset_mid();
        test_tile18();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
